// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the data memory arbiter.
//   Provides the arbiter FSM state enum, the read-owner enum and the
//   default address/data widths used by data_mem_arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 24;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LD} owner_e;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of cycles the loader has waited for a grant.
//   clk, rst (sync, active-low), inc (loader waiting), clr (loader granted or idle),
//   at_max (count has reached MAX).
module arb_wait_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : (inc && !at_max) ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= cnt_d;
    end
    assign at_max = cnt_q == 8'(MAX);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port synchronous data RAM between the CPU MEM stage and a loader.
//   Optional feature macro: ARB_PERF_CNT_EN adds perf_conflicts/perf_stalls counters.
//   clk, rst (sync, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_stall, cpu_rdata/cpu_rvalid
//   ld_req/ld_we/ld_lock/ld_addr/ld_wdata -> ld_gnt, ld_rdata/ld_rvalid
//   mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM (1-cycle latency)
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_conflicts,
    output logic [15:0]       perf_stalls
`endif
);
    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       at_max, lock_hold, cpu_gnt, ld_gnt_c;

    arb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .inc    (ld_req && !ld_gnt_c),
        .clr    (ld_gnt_c || !ld_req),
        .at_max (at_max)
    );

    // A lock only holds while the loader keeps both req and lock high; the
    // cycle either drops falls back to normal arbitration. Grants are masked
    // while rst is low so nothing reaches the RAM during reset.
    always_comb begin
        lock_hold = state_q == LOCKED && ld_req && ld_lock;
        cpu_gnt   = rst && cpu_req && !lock_hold && !(ld_req && at_max);
        ld_gnt_c  = rst && ld_req && !cpu_gnt;
        state_d   = (ld_gnt_c && ld_lock) ? LOCKED : IDLE;
        owner_d   = (cpu_gnt && !cpu_we) ? OWN_CPU : (ld_gnt_c && !ld_we) ? OWN_LD : OWN_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign cpu_stall  = rst && cpu_req && !cpu_gnt;
    assign ld_gnt     = ld_gnt_c;
    assign mem_en     = cpu_gnt || ld_gnt_c;
    assign mem_we     = cpu_gnt ? cpu_we : ld_gnt_c && ld_we;
    assign mem_addr   = cpu_gnt ? cpu_addr : ld_gnt_c ? ld_addr : '0;
    assign mem_wdata  = cpu_gnt ? cpu_wdata : ld_gnt_c ? ld_wdata : '0;
    assign cpu_rvalid = rst && owner_q == OWN_CPU;
    assign ld_rvalid  = rst && owner_q == OWN_LD;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_conf_q, perf_stall_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_conf_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_conf_q  <= (cpu_req && ld_req && !(&perf_conf_q)) ? perf_conf_q + 16'd1 : perf_conf_q;
            perf_stall_q <= (cpu_stall && !(&perf_stall_q)) ? perf_stall_q + 16'd1 : perf_stall_q;
        end
    end
    assign perf_conflicts = perf_conf_q;
    assign perf_stalls    = perf_stall_q;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: table-driven check of data_mem_arbiter with a read-return scoreboard.
module tb_data_mem_arbiter;
    logic        clk = 0;
    logic        rst = 0;
    logic        cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0, ld_lock = 0;
    logic [17:0] cpu_addr = '0, ld_addr = '0;
    logic [23:0] cpu_wdata = '0, ld_wdata = '0;
    logic        cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid, mem_en, mem_we;
    logic [23:0] cpu_rdata, ld_rdata, mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic [17:0] mem_addr;

    typedef struct {
        logic        rst, cr, cw;
        logic [17:0] ca;
        logic        lr, lw, ll;
        logic [17:0] la;
        int          g;
    } vec_t;
    typedef struct {
        int          own;
        logic [23:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    data_mem_arbiter #(.ADDR_W(18), .DATA_W(24), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ram_f(input logic [17:0] a);
        return {a[5:0], a} ^ 24'hA5C3E1;
    endfunction
    function automatic logic [23:0] cwd(input logic [17:0] a);
        return {6'h15, a};
    endfunction
    function automatic logic [23:0] lwd(input logic [17:0] a);
        return {6'h2B, a};
    endfunction

    always @(posedge clk)
        mem_rdata <= (mem_en && !mem_we) ? ram_f(mem_addr) : 24'($urandom);

    function automatic vec_t mk(input logic r, cr, cw, input logic [17:0] ca,
                                input logic lr, lw, ll, input logic [17:0] la, input int g);
        vec_t v;
        v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca;
        v.lr = lr; v.lw = lw; v.ll = ll; v.la = la; v.g = g;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = cwd(v.ca);
        ld_req = v.lr; ld_we = v.lw; ld_lock = v.ll; ld_addr = v.la; ld_wdata = lwd(v.la);
    endtask

    task automatic pop_check(input logic cur_rst);
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (!cur_rst) e.own = 0;
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.own == 1));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(e.own == 2));
        chk("cpu_rdata", 32'(cpu_rdata), e.own == 1 ? 32'(e.data) : 32'd0);
        chk("ld_rdata", 32'(ld_rdata), e.own == 2 ? 32'(e.data) : 32'd0);
    endtask

    task automatic comb_check(input vec_t v, input int idx);
        exp_t e;
        chk($sformatf("mem_en[%0d]", idx), 32'(mem_en), 32'(v.g != 0));
        chk($sformatf("ld_gnt[%0d]", idx), 32'(ld_gnt), 32'(v.g == 2));
        chk($sformatf("cpu_stall[%0d]", idx), 32'(cpu_stall), 32'(v.rst && v.cr && v.g != 1));
        if (v.g != 0) begin
            chk($sformatf("mem_we[%0d]", idx), 32'(mem_we), 32'(v.g == 1 ? v.cw : v.lw));
            chk($sformatf("mem_addr[%0d]", idx), 32'(mem_addr), 32'(v.g == 1 ? v.ca : v.la));
            chk($sformatf("mem_wdata[%0d]", idx), 32'(mem_wdata), 32'(v.g == 1 ? cwd(v.ca) : lwd(v.la)));
        end
        e.own  = (v.g == 1 && !v.cw) ? 1 : (v.g == 2 && !v.lw) ? 2 : 0;
        e.data = ram_f(v.g == 1 ? v.ca : v.la);
        sb.push_back(e);
    endtask

    initial begin
        int c;
        bit found;
        // reset with requests present: nothing granted, no stall
        vecs.push_back(mk(0, 1, 0, 18'h00010, 1, 0, 0, 18'h00020, 0));
        vecs.push_back(mk(0, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));
        // lone CPU read, then idle to see its return
        vecs.push_back(mk(1, 1, 0, 18'h00010, 0, 0, 0, 18'h0, 1));
        vecs.push_back(mk(1, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));
        // CPU write: no return
        vecs.push_back(mk(1, 1, 1, 18'h00123, 0, 0, 0, 18'h0, 1));
        // loader read at top address then CPU read: back-to-back returns
        vecs.push_back(mk(1, 0, 0, 18'h0, 1, 0, 0, 18'h3FFFF, 2));
        vecs.push_back(mk(1, 1, 0, 18'h00020, 0, 0, 0, 18'h0, 1));
        vecs.push_back(mk(1, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));
        // contention: CPU wins 8 cycles, loader forced on the 9th, CPU again after
        for (int k = 0; k < 9; k++)
            vecs.push_back(mk(1, 1, 0, 18'(32'h40 + k), 1, 1, 0, 18'h00100, k < 8 ? 1 : 2));
        vecs.push_back(mk(1, 1, 0, 18'h00050, 1, 1, 0, 18'h00100, 1));
        vecs.push_back(mk(1, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));
        // locked burst: CPU stalled 5 cycles, granted when lock drops
        vecs.push_back(mk(1, 0, 0, 18'h0, 1, 1, 1, 18'h00200, 2));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 1, 0, 18'h00060, 1, 1, 1, 18'(32'h201 + k), 2));
        vecs.push_back(mk(1, 1, 0, 18'h00060, 1, 1, 0, 18'h00206, 1));
        vecs.push_back(mk(1, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));
        // lock released by ld_req dropping
        vecs.push_back(mk(1, 0, 0, 18'h0, 1, 1, 1, 18'h00300, 2));
        vecs.push_back(mk(1, 1, 0, 18'h00070, 0, 1, 1, 18'h00301, 1));
        vecs.push_back(mk(1, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));
        // reset while locked with a read pending
        vecs.push_back(mk(1, 0, 0, 18'h0, 1, 0, 1, 18'h3FFFF, 2));
        vecs.push_back(mk(0, 1, 0, 18'h00080, 1, 0, 1, 18'h3FFFE, 0));
        vecs.push_back(mk(1, 1, 0, 18'h00090, 1, 1, 1, 18'h3FFFD, 1));
        vecs.push_back(mk(1, 0, 0, 18'h0, 0, 0, 0, 18'h0, 0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1 apply(vecs[i]);
            #1 pop_check(vecs[i].rst);
            @(negedge clk);
            comb_check(vecs[i], i);
        end
        @(posedge clk);
        #2 pop_check(rst);

        // sustained write contention: loader forced in every 9th cycle
        cpu_req = 1; cpu_we = 1; ld_req = 1; ld_we = 1; ld_lock = 0;
        for (int r = 0; r < 2; r++) begin
            found = 0;
            c = 0;
            for (int k = 1; k <= 20 && !found; k++) begin
                @(negedge clk);
                c = k;
                if (ld_gnt) found = 1;
                else @(posedge clk);
            end
            chk($sformatf("forced_grant_seen[%0d]", r), 32'(found), 32'd1);
            chk($sformatf("forced_grant_cycle[%0d]", r), 32'(c), 32'd9);
            chk($sformatf("forced_stall[%0d]", r), 32'(cpu_stall), 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("post_force_cpu_gnt", 32'(cpu_stall), 32'd0);
        cpu_req = 0; ld_req = 0;
        @(negedge clk);
        chk("idle_mem_en", 32'(mem_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
